// File: rtl/alu_seq_top.sv
// Button-driven sequential ALU front end.
// Operands and the opcode are loaded from the switches by synchronised, edge-detected
// button presses. The registered result, flags and valid indicator drive the board outputs.
module alu_seq_top #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [2:0]         i_buttons,
    input  logic [NB_DATA-1:0] i_switches,
    input  logic               i_acc_mode,
    output logic [NB_DATA-1:0] o_leds,
    output logic [3:0]         o_flags,
    output logic               o_valid
);

    localparam int unsigned MSB    = NB_DATA - 1;
    localparam int unsigned NB_BTN = 3;
    localparam int unsigned NB_WRM = 2;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(32);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(34);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(36);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(37);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(38);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(39);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(3);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(2);

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_HAVE_A,
        ST_HAVE_B,
        ST_HAVE_AB,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [NB_BTN-1:0]  sync1, sync2, prev;
    logic [NB_WRM-1:0]  warm;
    logic [NB_BTN-1:0]  edges_c;
    logic               armed_c;
    logic               exec_c, load_a_c, load_b_c;

    logic [NB_DATA-1:0] reg_a, reg_b;
    logic [NB_OP-1:0]   op_c;
    logic [NB_DATA:0]   sum_c, diff_c;
    logic               shift_big_c;
    logic [NB_DATA-1:0] res_c;
    logic               err_c, ovf_c, cry_c, zero_c;

    // Button synchroniser, edge history and post-reset warm-up counter.
    // During warm-up the edge FF just tracks the synchronised level, so a button
    // already held when reset is released never produces a command.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            warm  <= '0;
        end else begin
            sync1 <= i_buttons;
            sync2 <= sync1;
            prev  <= sync2;
            if (warm != NB_WRM'(3)) begin
                warm <= warm + NB_WRM'(1);
            end
        end
    end

    // Command decode with priority execute > load B > load A.
    assign edges_c  = sync2 & ~prev;
    assign armed_c  = (warm == NB_WRM'(3));
    assign exec_c   = armed_c & edges_c[2];
    assign load_b_c = armed_c & edges_c[1] & ~edges_c[2];
    assign load_a_c = armed_c & edges_c[0] & ~edges_c[1] & ~edges_c[2];

    // Operand arithmetic shared by the ALU cases.
    assign op_c        = i_switches[NB_OP-1:0];
    assign sum_c       = {1'b0, reg_a} + {1'b0, reg_b};
    assign diff_c      = {1'b0, reg_a} - {1'b0, reg_b};
    assign shift_big_c = (reg_b >= NB_DATA'(NB_DATA));

    // ALU: result and flags for the opcode currently on the switches.
    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        ovf_c = 1'b0;
        cry_c = 1'b0;
        case (op_c)
            OP_ADD: begin
                res_c = sum_c[NB_DATA-1:0];
                cry_c = sum_c[NB_DATA];
                ovf_c = (reg_a[MSB] == reg_b[MSB]) && (res_c[MSB] != reg_a[MSB]);
            end
            OP_SUB: begin
                res_c = diff_c[NB_DATA-1:0];
                cry_c = diff_c[NB_DATA];
                ovf_c = (reg_a[MSB] != reg_b[MSB]) && (res_c[MSB] != reg_a[MSB]);
            end
            OP_AND: res_c = reg_a & reg_b;
            OP_OR:  res_c = reg_a | reg_b;
            OP_XOR: res_c = reg_a ^ reg_b;
            OP_NOR: res_c = ~(reg_a | reg_b);
            OP_SRL: res_c = shift_big_c ? '0 : (reg_a >> reg_b);
            OP_SRA: res_c = shift_big_c ? {NB_DATA{reg_a[MSB]}}
                                        : NB_DATA'($signed(reg_a) >>> reg_b);
            default: err_c = 1'b1;
        endcase
    end

    assign zero_c = (res_c == '0);

    // Load-status state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: execute always lands in DONE, loads accumulate operand status.
    always_comb begin
        state_next = state;
        if (exec_c) begin
            state_next = ST_DONE;
        end else if (load_a_c) begin
            case (state)
                ST_EMPTY:  state_next = ST_HAVE_A;
                ST_HAVE_A: state_next = ST_HAVE_A;
                default:   state_next = ST_HAVE_AB;
            endcase
        end else if (load_b_c) begin
            case (state)
                ST_EMPTY:  state_next = ST_HAVE_B;
                ST_HAVE_B: state_next = ST_HAVE_B;
                default:   state_next = ST_HAVE_AB;
            endcase
        end
    end

    // Operand registers; chain mode writes the result back into A on execute.
    // The opcode is consumed only on the execute edge, so it is folded into the result registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            reg_a <= '0;
            reg_b <= '0;
        end else begin
            if (load_a_c) begin
                reg_a <= i_switches;
            end else if (exec_c && i_acc_mode) begin
                reg_a <= res_c;
            end
            if (load_b_c) begin
                reg_b <= i_switches;
            end
        end
    end

    // Registered result, flags and valid indicator.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_leds  <= '0;
            o_flags <= '0;
            o_valid <= 1'b0;
        end else begin
            if (exec_c) begin
                o_leds  <= res_c;
                o_flags <= {err_c, ovf_c, cry_c, zero_c};
            end
            o_valid <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_alu_seq_top.sv
// Self-checking bench for alu_seq_top: an operand/result model updated per command,
// one per-cycle compare process, and literal expectations for the worked examples.
module tb_alu_seq_top;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic [2:0]   btn;
    logic [W-1:0] sw;
    logic         acc;
    logic [W-1:0] o_leds;
    logic [3:0]   o_flags;
    logic         o_valid;

    // Model state (written only by the stimulus process)
    logic [W-1:0] m_a, m_b, m_leds;
    logic [3:0]   m_flags;
    logic         m_valid;
    bit           chk_en;

    // Literal expectation handshake (seq written by stimulus, done by compare)
    int           pin_seq;
    int           pin_done;
    logic [W-1:0] pin_leds;
    logic [3:0]   pin_flags;
    logic         pin_valid;
    string        pin_name;

    int n_checks;
    int n_fail;

    alu_seq_top #(.NB_DATA(W), .NB_OP(6)) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_buttons  (btn),
        .i_switches (sw),
        .i_acc_mode (acc),
        .o_leds     (o_leds),
        .o_flags    (o_flags),
        .o_valid    (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic.
    function automatic void ref_alu(input int unsigned a, input int unsigned b, input int unsigned op,
                                    output int unsigned res, output logic [3:0] fl);
        int   sa, sb, s;
        logic err, ov, cy;
        err = 1'b0; ov = 1'b0; cy = 1'b0; res = 0;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        case (op)
            32: begin res = (a + b) % 256; cy = (a + b) > 255; s = sa + sb; ov = (s > 127) || (s < -128); end
            34: begin res = (a + 256 - b) % 256; cy = (a < b); s = sa - sb; ov = (s > 127) || (s < -128); end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = (~(a | b)) & 255;
            2:  res = (b >= 8) ? 0 : (a >> b);
            3:  begin
                    if (b >= 8) res = (sa < 0) ? 255 : 0;
                    else        res = (sa >>> b) & 255;
                end
            default: begin res = 0; err = 1'b1; end
        endcase
        fl = {err, ov, cy, (res == 0)};
    endfunction

    task automatic model_cmd(input logic [2:0] b, input logic [W-1:0] s, input logic a_mode);
        int unsigned r;
        logic [3:0]  f;
        if (b[2]) begin
            ref_alu(m_a, m_b, s[5:0], r, f);
            m_leds  = W'(r);
            m_flags = f;
            m_valid = 1'b1;
            if (a_mode) m_a = W'(r);
        end else if (b[1]) begin
            m_b = s; m_valid = 1'b0;
        end else if (b[0]) begin
            m_a = s; m_valid = 1'b0;
        end
    endtask

    // Drive a button pattern before edge N; the command lands at N+2.
    task automatic press(input logic [2:0] b, input logic [W-1:0] s, input logic a_mode, input int hold);
        @(negedge clk);
        btn = b; sw = s; acc = a_mode;
        repeat (3) @(posedge clk);
        #1 model_cmd(b, s, a_mode);
        if (hold > 3) repeat (hold - 3) @(posedge clk);
        @(negedge clk);
        btn = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic pin(input logic [W-1:0] l, input logic [3:0] f, input logic v, input string name);
        pin_leds = l; pin_flags = f; pin_valid = v; pin_name = name;
        pin_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
        press(3'b001, a, 1'b0, 3);
        press(3'b010, b, 1'b0, 3);
    endtask

    // Single compare process: model every cycle, plus any pending literal expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (o_leds !== m_leds || o_flags !== m_flags || o_valid !== m_valid) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t leds=%h exp=%h flags=%b exp=%b valid=%b exp=%b",
                         $time, o_leds, m_leds, o_flags, m_flags, o_valid, m_valid);
            end
        end
        if (pin_seq != pin_done) begin
            pin_done = pin_seq;
            n_checks++;
            if (o_leds !== pin_leds || o_flags !== pin_flags || o_valid !== pin_valid) begin
                n_fail++;
                $display("FAIL %s t=%0t leds=%h exp=%h flags=%b exp=%b valid=%b exp=%b",
                         pin_name, $time, o_leds, pin_leds, o_flags, pin_flags, o_valid, pin_valid);
            end
        end
    end

    initial begin
        int unsigned ops[8];
        logic [W-1:0] ra, rb;
        logic [2:0]   mask;
        ops = '{32, 34, 36, 37, 38, 39, 2, 3};
        n_checks = 0; n_fail = 0;
        pin_seq = 0; pin_done = 0;
        pin_leds = '0; pin_flags = '0; pin_valid = 1'b0; pin_name = "none";
        chk_en = 1'b0;
        m_a = '0; m_b = '0; m_leds = '0; m_flags = '0; m_valid = 1'b0;
        rst_n = 1'b0; btn = '0; sw = '0; acc = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        pin(8'h00, 4'b0000, 1'b0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Worked examples
        load_ab(8'h5A, 8'h0F);
        press(3'b100, 8'h20, 1'b0, 3);
        pin(8'h69, 4'b0000, 1'b1, "add_5a_0f");

        load_ab(8'h80, 8'h80);
        press(3'b100, 8'h20, 1'b0, 3);
        pin(8'h00, 4'b0111, 1'b1, "add_80_80");

        load_ab(8'h00, 8'h01);
        press(3'b100, 8'h22, 1'b0, 3);
        pin(8'hFF, 4'b0010, 1'b1, "sub_00_01");

        load_ab(8'h7F, 8'h01);
        press(3'b100, 8'h20, 1'b0, 3);
        pin(8'h80, 4'b0100, 1'b1, "add_ovf");

        load_ab(8'h90, 8'h09);
        press(3'b100, 8'h03, 1'b0, 3);
        pin(8'hFF, 4'b0000, 1'b1, "sra_big");
        press(3'b100, 8'h02, 1'b0, 3);
        pin(8'h00, 4'b0001, 1'b1, "srl_big");

        press(3'b100, 8'h3F, 1'b0, 3);
        pin(8'h00, 4'b1001, 1'b1, "bad_opcode");

        press(3'b010, 8'h11, 1'b0, 3);
        pin(8'h00, 4'b1001, 1'b0, "load_b_after_done");

        // Chain mode
        load_ab(8'h01, 8'h01);
        for (int i = 0; i < 4; i++) begin
            press(3'b100, 8'h20, 1'b1, 3);
            pin(W'(i + 2), 4'b0000, 1'b1, "chain_add");
        end

        // Simultaneous edges: only execute acts
        load_ab(8'h05, 8'h03);
        press(3'b111, 8'h20, 1'b0, 3);
        pin(8'h08, 4'b0000, 1'b1, "priority_111");
        press(3'b100, 8'h20, 1'b0, 3);
        pin(8'h08, 4'b0000, 1'b1, "priority_ab_kept");

        // Held button: exactly one chained execute
        load_ab(8'h01, 8'h01);
        press(3'b100, 8'h20, 1'b1, 20);
        pin(8'h02, 4'b0000, 1'b1, "hold_one_cmd");
        press(3'b100, 8'h20, 1'b0, 3);
        pin(8'h03, 4'b0000, 1'b1, "hold_a_once");

        // Randomised per-opcode runs with occasional mixed-button presses
        foreach (ops[k]) begin
            for (int j = 0; j < 11; j++) begin
                ra = W'($urandom);
                rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 11)) : W'($urandom);
                load_ab(ra, rb);
                press(3'b100, {2'($urandom), 6'(ops[k])}, ($urandom_range(0, 3) == 0), 3);
                if ($urandom_range(0, 4) == 0) begin
                    mask = 3'($urandom_range(1, 7));
                    press(mask, W'($urandom), $urandom_range(0, 1) == 1, 3);
                end
            end
        end

        // Asynchronous reset between load B and execute
        load_ab(8'h33, 8'h44);
        @(posedge clk);
        #2 rst_n = 1'b0;
        m_a = '0; m_b = '0; m_leds = '0; m_flags = '0; m_valid = 1'b0;
        pin(8'h00, 4'b0000, 1'b0, "reset_async");
        #2;
        btn = 3'b001; sw = 8'hAA;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        btn = 3'b000;
        repeat (4) @(negedge clk);
        pin(8'h00, 4'b0000, 1'b0, "held_through_reset");
        press(3'b010, 8'h01, 1'b0, 3);
        press(3'b100, 8'h20, 1'b0, 3);
        pin(8'h01, 4'b0000, 1'b1, "after_reset_add");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_top.md
# alu_seq_top

Parametrised, button-driven ALU front end for the board-level top: operands A and B and the opcode are loaded from the switches by button presses and the registered result drives the LEDs. Unlike the fixed 8-bit top, it adds:
- width parameters,
- synchronised, edge-triggered buttons with a defined priority,
- a status-flag output,
- a result-valid indicator,
- an accumulator (chain) mode that writes each result back into A.

## Interface
- NB_DATA, 8, operand/result width (≥4)
- NB_OP, 6, opcode width (low NB_OP bits of switches)
- i_clock  in  1  single system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset (reset while 0)
- i_buttons  in  3  raw buttons: [0] load A, [1] load B, [2] load opcode + execute
- i_switches  in  NB_DATA  data/opcode source
- i_acc_mode  in  1  chain mode: execute also writes result into A
- o_leds  out  NB_DATA  registered result
- o_flags  out  4  {error, overflow, carry, zero}, registered with result
- o_valid  out  1  result corresponds to current A/B/opcode

## Operation
- Button path: each bit goes through a 2-FF synchroniser, then rising-edge detect against a third FF. One detected edge = one command. A held level issues no further commands.
- Priority when several edges are detected in the same cycle: [2] > [1] > [0]. Only the highest acts; the others are discarded, not queued.
- Load A: reg_a ← i_switches. Load B: reg_b ← i_switches. Either load clears o_valid.
- Execute: reg_op ← i_switches[NB_OP-1:0]. The result is computed from reg_a, reg_b and the new opcode and registered into o_leds and o_flags. o_valid ← 1.
- Opcodes and results:
  - 32 ADD: A+B
  - 34 SUB: A−B
  - 36 AND
  - 37 OR
  - 38 XOR
  - 39 NOR: ~(A|B)
  - 3 SRA: A>>>B, A signed
  - 2 SRL: A>>B
- Results wrap modulo 2^NB_DATA.
- Shift amount is B read as unsigned. If B ≥ NB_DATA: SRL gives 0; SRA gives all bits equal to A[NB_DATA-1].
- Flags:
  - zero = (result == 0), for every opcode.
  - carry:
    - ADD: carry-out.
    - SUB: borrow, i.e. A < B unsigned.
    - All other opcodes: 0.
  - overflow: signed overflow for ADD/SUB, 0 otherwise.
  - error:
    - Unknown opcode: error = 1, result = 0, zero = 1, o_valid still set.
    - Any defined opcode: error = 0.
- Chain mode: if i_acc_mode = 1 at execute, reg_a ← result in the same cycle; o_valid stays 1. i_acc_mode is sampled only at execute.
- FSM, tracking load status for o_valid:
  - States: EMPTY, HAVE_A, HAVE_B, HAVE_AB, DONE.
  - Load A: EMPTY→HAVE_A, HAVE_B→HAVE_AB, HAVE_A stays HAVE_A, HAVE_AB stays HAVE_AB, DONE→HAVE_AB.
  - Load B: EMPTY→HAVE_B, HAVE_A→HAVE_AB, HAVE_B stays HAVE_B, HAVE_AB stays HAVE_AB, DONE→HAVE_AB.
  - Execute: from any state → DONE.
  - Execute from a state other than HAVE_AB/DONE uses whatever A/B values are held (reset value 0). It is legal, not an error.
  - o_valid = (state == DONE).

## Timing
- On reset assertion (asynchronous): o_leds=0, o_flags=0, o_valid=0, reg_a=reg_b=reg_op=0, synchroniser/edge FFs=0, state=EMPTY.
- Button high before rising edge N → its command takes effect at edge N+2 and is visible after N+2. Worst case after an async transition: 3 edges.
- Switches are sampled at the edge where the command takes effect. They must be stable from edge N through N+2.
- Minimum spacing between commands on the same button: low for ≥2 cycles, then high.
- Button already high when reset is released → no command; edge FFs start at 0 only after the first sample. To avoid a spurious edge, the edge FF is loaded with the synchronised level during the first 2 cycles after reset.
- Reset asserted mid-sequence aborts everything. No partial register updates survive.
- Result path is a single registered stage with no extra latency. o_leds/o_flags change only on an execute edge.

## Test plan
- Per opcode: press A=0x5A, B=0x0F, execute 32 → o_leds=0x69 by edge N+2, o_valid=1, flags=0000. Repeat for 34/36/37/38/39/2/3 against a reference model, 11 random pairs each.
- Flags: A=0x80, B=0x80, ADD → leds=0x00, flags={0,1,1,1}. A=0x00, B=0x01, SUB → leds=0xFF, carry=1, overflow=0, zero=0. A=0x7F, B=0x01, ADD → overflow=1.
- Shifts and opcodes:
  - A=0x90, B=9, SRA → 0xFF.
  - Same operands, SRL → 0x00.
  - Opcode 0x3F → leds=0, error=1, zero=1.
- Chain: i_acc_mode=1, A=1, B=1, execute ADD 4 times (button toggled) → o_leds 2, 3, 4, 5.
- Priority and edges: buttons 3'b111 rising together → only execute occurs, A/B unchanged. Button held high 20 cycles → exactly one command. Load B after DONE → o_valid=0.
- Reset: i_reset low for 1 cycle mid-operation (between load B and execute) → all outputs 0 immediately, asynchronously. Button held through reset release → no command.
